// File: rtl/arbiter_r1_4ph.sv
// Two-client mutual-exclusion arbiter for 4-phase (return-to-zero) req/ack
// channels. The winning client's handshake is forwarded to one shared
// downstream channel (r0/a0). Ties are broken round-robin.
//
// Handshake: a client raises ri and holds it until ai=1, then drops ri and
// waits for ai=0 before raising again. Downstream, r0 rises and stays high
// until a0=1, and r0 falls and stays low until a0=0. ai follows a0: it rises
// only after a0 is seen high and falls only after a0 is seen low.
module arbiter_r1_4ph #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic r1,
  output logic a1,
  input  logic r2,
  output logic a2,
  output logic r0,
  input  logic a0
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ1 = 3'd1,
    S_ACK1 = 3'd2,
    S_REL1 = 3'd3,
    S_REQ2 = 3'd4,
    S_ACK2 = 3'd5,
    S_REL2 = 3'd6
  } state_t;

  // {a0, r2, r1} before and after synchronization
  logic [2:0] raw_in;
  logic [2:0] sync_in;
  logic       r1_s;
  logic       r2_s;
  logic       a0_s;

  assign raw_in = {a0, r2, r1};

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign sync_in = raw_in;
    end else begin : g_sync
      logic [2:0] sync_q [SYNC_STAGES];
      logic [2:0] sync_d [SYNC_STAGES];

      // Shift chain: stage 0 captures the raw inputs, each later stage copies the previous one
      always_comb begin
        sync_d[0] = raw_in;
        for (int i = 1; i < SYNC_STAGES; i++) begin
          sync_d[i] = sync_q[i-1];
        end
      end

      // Synchronizer flops, cleared on reset so stale inputs re-enter in lock-step
      always_ff @(posedge clk) begin
        for (int i = 0; i < SYNC_STAGES; i++) begin
          if (rst) begin
            sync_q[i] <= 3'b000;
          end else begin
            sync_q[i] <= sync_d[i];
          end
        end
      end

      assign sync_in = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  assign r1_s = sync_in[0];
  assign r2_s = sync_in[1];
  assign a0_s = sync_in[2];

  state_t state_q, state_d;
  logic   ptr_q, ptr_d;   // 0: client 1 wins the next tie, 1: client 2
  logic   a1_q, a1_d;
  logic   a2_q, a2_d;
  logic   r0_q, r0_d;

  // Next-state logic; outputs are decoded from the next state so they leave flops
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      S_IDLE: begin
        // A new grant needs a quiet downstream ack, so a stale a0 cannot leak into ai
        if (!a0_s) begin
          if (r1_s && r2_s) begin
            state_d = ptr_q ? S_REQ2 : S_REQ1;
          end else if (r1_s) begin
            state_d = S_REQ1;
          end else if (r2_s) begin
            state_d = S_REQ2;
          end
        end
      end
      S_REQ1: if (a0_s)  state_d = S_ACK1;
      S_ACK1: if (!r1_s) state_d = S_REL1;
      S_REL1: begin
        if (!a0_s) begin
          state_d = S_IDLE;
          ptr_d   = 1'b1;
        end
      end
      S_REQ2: if (a0_s)  state_d = S_ACK2;
      S_ACK2: if (!r2_s) state_d = S_REL2;
      S_REL2: begin
        if (!a0_s) begin
          state_d = S_IDLE;
          ptr_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    r0_d = (state_d == S_REQ1) || (state_d == S_ACK1) ||
           (state_d == S_REQ2) || (state_d == S_ACK2);
    a1_d = (state_d == S_ACK1) || (state_d == S_REL1);
    a2_d = (state_d == S_ACK2) || (state_d == S_REL2);
  end

  // State, pointer and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= 1'b0;
      r0_q    <= 1'b0;
      a1_q    <= 1'b0;
      a2_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      r0_q    <= r0_d;
      a1_q    <= a1_d;
      a2_q    <= a2_d;
    end
  end

  assign r0 = r0_q;
  assign a1 = a1_q;
  assign a2 = a2_q;

endmodule

// File: tb/tb_arbiter_r1_4ph.sv
// Bench for arbiter_r1_4ph: client handshake tasks, a delayed-ack downstream
// model, a grant-order reference model feeding an expected queue, and a
// monitor that pops and compares on every grant.
module tb_arbiter_r1_4ph;

  logic clk = 1'b0;
  logic rst;
  logic r1, r2;
  logic a0 = 1'b0;
  logic a1, a2, r0;

  arbiter_r1_4ph #(.SYNC_STAGES(2)) dut (
    .clk (clk),
    .rst (rst),
    .r1  (r1),
    .a1  (a1),
    .r2  (r2),
    .a2  (a2),
    .r0  (r0),
    .a0  (a0)
  );

  // Clock
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected grant order (client ids); last_served drives the tie rule
  logic [1:0] exp_q[$];
  int last_served = 2;

  // Downstream model: a0 is r0 delayed by dly cycles
  int dly = 3;
  logic [511:0] hist = '0;

  bit free_run = 1'b0;
  int grants1 = 0;
  int grants2 = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: lone request wins; tie goes to the client not served last
  task automatic push_single(input int c);
    exp_q.push_back(2'(c));
    last_served = c;
  endtask

  task automatic push_tie();
    int w;
    w = (last_served == 2) ? 1 : 2;
    exp_q.push_back(2'(w));
    exp_q.push_back(2'(3 - w));
    last_served = 3 - w;
  endtask

  always @(negedge clk) begin
    hist = {hist[510:0], r0};
    a0 = hist[dly-1];
  end

  task automatic set_dly(input int d);
    hist = '0;
    dly = d;
  endtask

  // Client driver tasks
  task automatic set_r(input int c, input logic v);
    if (c == 1) r1 = v;
    else r2 = v;
  endtask

  function automatic logic get_a(input int c);
    return (c == 1) ? a1 : a2;
  endfunction

  task automatic wait_a(input int c, input logic v, input string nm);
    for (int k = 0; k < 4000; k++) begin
      if (get_a(c) === v) break;
      @(negedge clk);
    end
    check(nm, 32'(get_a(c) === v), 32'd1);
  endtask

  task automatic client_hs(input int c, input int hold);
    set_r(c, 1'b1);
    wait_a(c, 1'b1, "ack_rise_timeout");
    repeat (hold) @(negedge clk);
    set_r(c, 1'b0);
    wait_a(c, 1'b0, "ack_fall_timeout");
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    r1 = 1'b0;
    r2 = 1'b0;
    exp_q.delete();
    last_served = 2;
    idle(2);
    rst = 1'b0;
    idle(3);
  endtask

  // Monitor / scoreboard
  logic a1_p = 1'b0, a2_p = 1'b0;
  int age1 = 0, age2 = 0;
  int last_rel = 0;
  bit other_waited = 1'b0;

  task automatic on_grant(input int c);
    logic [1:0] e;
    check("grant_r0_high", 32'(r0), 32'd1);
    check("grant_a0_high", 32'(a0), 32'd1);
    if (free_run) begin
      if (c == 1) grants1++;
      else grants2++;
      check("no_starvation", 32'(c == last_rel && other_waited), 32'd0);
    end else if (exp_q.size() == 0) begin
      check("unexpected_grant", 32'(c), 32'd0);
    end else begin
      e = exp_q.pop_front();
      check("grant_order", 32'(c), 32'(e));
    end
  endtask

  task automatic on_release(input int c);
    check("release_a0_low", 32'(a0), 32'd0);
    check("release_r0_low", 32'(r0), 32'd0);
    last_rel = c;
    other_waited = (c == 1) ? (age2 >= 6) : (age1 >= 6);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      a1_p = 1'b0;
      a2_p = 1'b0;
      last_rel = 0;
      other_waited = 1'b0;
    end else begin
      if (a1 || a2) check("mutex", 32'(a1 & a2), 32'd0);
      if (a1 && !a1_p) on_grant(1);
      if (a2 && !a2_p) on_grant(2);
      if (!a1 && a1_p) on_release(1);
      if (!a2 && a2_p) on_release(2);
      a1_p = a1;
      a2_p = a2;
    end
    age1 = (r1 && !a1) ? age1 + 1 : 0;
    age2 = (r2 && !a2) ? age2 + 1 : 0;
  end

  // Watchdog
  initial begin
    #600000;
    n_fail++;
    $display("FAIL watchdog: simulation did not complete, failures %0d", n_fail);
    $fatal(1, "watchdog expired");
  end

  // Stimulus
  initial begin
    int pat, h1, h2, first, gap;
    bit bad;

    rst = 1'b1;
    r1 = 1'b1;
    r2 = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("reset_a1", 32'(a1), 32'd0);
      check("reset_a2", 32'(a2), 32'd0);
      check("reset_r0", 32'(r0), 32'd0);
    end

    // Tie right after reset, then a second tie
    push_tie();
    rst = 1'b0;
    fork
      client_hs(1, 3);
      client_hs(2, 4);
    join
    idle(4);
    push_tie();
    fork
      client_hs(1, 2);
      client_hs(2, 1);
    join
    idle(4);

    // Single client 1, a0 = r0 delayed 3 cycles
    set_dly(3);
    for (int i = 0; i < 10; i++) begin
      push_single(1);
      client_hs(1, 2);
      idle(2);
    end

    // Randomized rounds
    for (int rnd = 0; rnd < 30; rnd++) begin
      pat = $urandom_range(0, 3);
      h1 = $urandom_range(0, 6);
      h2 = $urandom_range(0, 6);
      set_dly($urandom_range(1, 8));
      case (pat)
        0: begin push_single(1); client_hs(1, h1); end
        1: begin push_single(2); client_hs(2, h2); end
        2: begin
          push_tie();
          fork
            client_hs(1, h1);
            client_hs(2, h2);
          join
        end
        default: begin
          first = $urandom_range(1, 2);
          gap = $urandom_range(1, 3);
          push_single(first);
          push_single(3 - first);
          fork
            client_hs(first, h1);
            begin
              idle(gap);
              client_hs(3 - first, h2);
            end
          join
        end
      endcase
      idle(3);
    end

    // Contention: both clients loop concurrently
    do_reset();
    set_dly(3);
    free_run = 1'b1;
    grants1 = 0;
    grants2 = 0;
    fork
      for (int i = 0; i < 10; i++) client_hs(1, 10);
      for (int j = 0; j < 10; j++) client_hs(2, 25);
    join
    idle(5);
    check("contention_grants1", 32'(grants1), 32'd10);
    check("contention_grants2", 32'(grants2), 32'd10);
    free_run = 1'b0;

    // Slow downstream
    do_reset();
    set_dly(300);
    push_single(2);
    push_single(1);
    fork
      client_hs(2, 5);
      begin
        idle(20);
        client_hs(1, 5);
      end
      begin
        idle(150);
        check("slow_r0_held", 32'(r0), 32'd1);
        check("slow_a2_low", 32'(a2), 32'd0);
        check("slow_a1_low", 32'(a1), 32'd0);
      end
    join
    idle(5);

    // Reset during ACK_1 with a0 high
    do_reset();
    set_dly(20);
    push_single(1);
    set_r(1, 1'b1);
    wait_a(1, 1'b1, "t6_ack_timeout");
    rst = 1'b1;
    @(negedge clk);
    check("midreset_a1", 32'(a1), 32'd0);
    check("midreset_a2", 32'(a2), 32'd0);
    check("midreset_r0", 32'(r0), 32'd0);
    rst = 1'b0;
    exp_q.delete();
    last_served = 2;
    bad = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (i == 15) r1 = 1'b0;
      @(negedge clk);
      if (a1 || a2 || r0) bad = 1'b1;
    end
    check("no_stale_grant", 32'(bad), 32'd0);
    push_single(2);
    client_hs(2, 3);
    idle(5);

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
